// File: rtl/uni_shift_pkg.sv
// Shared definitions for the sequenced universal shift register:
// op-code values, FSM state encoding and an op classification helper.
package uni_shift_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;
    localparam logic [2:0] OP_ASR = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Ops that move bits one position per step and honour the count field.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
               (op == OP_ROR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: applies one shift/rotate step to value
// and reports the bit pushed out of the register.
module shift_step
    import uni_shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] value,
    input  logic         left_in,
    input  logic         right_in,
    output logic [N-1:0] next,
    output logic         bit_out
);

    generate
        if (N == 1) begin : g_single
            // A 1-bit register has nothing to rotate; fills still replace it.
            always_comb begin
                next    = value;
                bit_out = value[0];
                case (op)
                    OP_SHL:  next = right_in;
                    OP_SHR:  next = left_in;
                    default: next = value;
                endcase
            end
        end else begin : g_multi
            always_comb begin
                // NOTE: defaults first so every path assigns every output; no latch.
                next    = value;
                bit_out = 1'b0;
                case (op)
                    OP_SHL: begin
                        next    = {value[N-2:0], right_in};
                        bit_out = value[N-1];
                    end
                    OP_SHR: begin
                        next    = {left_in, value[N-1:1]};
                        bit_out = value[0];
                    end
                    OP_ROL: begin
                        next    = {value[N-2:0], value[N-1]};
                        bit_out = value[N-1];
                    end
                    OP_ROR: begin
                        next    = {value[0], value[N-1:1]};
                        bit_out = value[0];
                    end
                    OP_ASR: begin
                        next    = {value[N-1], value[N-1:1]};
                        bit_out = value[0];
                    end
                    default: begin
                        next    = value;
                        bit_out = 1'b0;
                    end
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/uni_shift_reg_seq.sv
// Universal shift register with multi-step commands run one bit per clock
// under a start/busy/done handshake; serial-out tracks the last expelled bit.
module uni_shift_reg_seq
    import uni_shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [CW-1:0] count,
    input  logic [N-1:0]  in,
    input  logic          left_in,
    input  logic          right_in,
    output logic [N-1:0]  out,
    output logic          busy,
    output logic          done,
    output logic          ser_out
);

    state_e        state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [2:0]    op_q, op_d;
    logic [N-1:0]  out_q, out_d;
    logic          done_q, done_d;
    logic          ser_q, ser_d;

    logic [2:0]    step_op;
    logic [N-1:0]  step_next;
    logic          step_bit;

    // The accept edge performs the first step with the live op; later steps use the latched op.
    assign step_op = (state_q == ST_RUN) ? op_q : op;

    shift_step #(.N(N)) u_step (
        .op       (step_op),
        .value    (out_q),
        .left_in  (left_in),
        .right_in (right_in),
        .next     (step_next),
        .bit_out  (step_bit)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        op_d    = op_q;
        out_d   = out_q;
        ser_d   = ser_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_LOAD) begin
                        out_d  = in;
                        done_d = 1'b1;
                    end else if (is_shift_op(op) && (count != '0)) begin
                        out_d = step_next;
                        ser_d = step_bit;
                        if (count == CW'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            op_d    = op;
                            rem_d   = count - CW'(1);
                            state_d = ST_RUN;
                        end
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                out_d = step_next;
                ser_d = step_bit;
                rem_d = rem_q - CW'(1);
                if (rem_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (clear) begin
            // NOTE: clear outranks everything, including a start on the same edge.
            state_q <= ST_IDLE;
            rem_q   <= '0;
            op_q    <= OP_NOP;
            out_q   <= '0;
            done_q  <= 1'b0;
            ser_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ser_q   <= ser_d;
        end
    end

    assign out     = out_q;
    assign busy    = (state_q == ST_RUN);
    assign done    = done_q;
    assign ser_out = ser_q;

endmodule

// File: tb/tb_uni_shift_reg_seq.sv
// Self-checking bench for uni_shift_reg_seq (N=8, CW=4): a chained command
// table plus hand-written sequences for busy-ignore, abort and clear corners.
module tb_uni_shift_reg_seq;
    import uni_shift_pkg::*;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic [2:0]    op;
    logic [CW-1:0] count;
    logic [N-1:0]  data_in;
    logic          left_in;
    logic          right_in;
    logic [N-1:0]  out;
    logic          busy;
    logic          done;
    logic          ser_out;

    int checks = 0;
    int errors = 0;

    uni_shift_reg_seq #(.N(N), .CW(CW)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .count    (count),
        .in       (data_in),
        .left_in  (left_in),
        .right_in (right_in),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .ser_out  (ser_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]    op;
        logic [CW-1:0] count;
        logic [N-1:0]  din;
        logic          li;
        logic          ri;
        logic [N-1:0]  exp_out;
        logic          exp_ser;
        int            exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one command at a negedge and follow it until done (bounded).
    task automatic run_cmd(input string tag, input vec_t v);
        int lat;
        int busy_cyc;
        @(negedge clock);
        start = 1'b1; op = v.op; count = v.count; data_in = v.din;
        left_in = v.li; right_in = v.ri;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            @(negedge clock);
            lat++;
        end
        check({tag, " done_seen"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(v.exp_lat - 1));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " out"}, 32'(out), 32'(v.exp_out));
        check({tag, " ser_out"}, 32'(ser_out), 32'(v.exp_ser));
        @(negedge clock);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    function automatic vec_t mk(input logic [2:0] o, input int c, input logic [7:0] d,
                                input logic li, input logic ri, input logic [7:0] eo,
                                input logic es, input int lat);
        vec_t v;
        v.op = o; v.count = CW'(c); v.din = d; v.li = li; v.ri = ri;
        v.exp_out = eo; v.exp_ser = es; v.exp_lat = lat;
        return v;
    endfunction

    initial begin
        int busy_seen;
        int done_seen;
        // Chained table: each command starts from the result of the previous one.
        vecs[0]  = mk(OP_LOAD, 0,  8'hA5, 0, 0, 8'hA5, 0, 1);
        vecs[1]  = mk(OP_SHL,  3,  8'h00, 0, 1, 8'h2F, 1, 3);
        vecs[2]  = mk(OP_LOAD, 0,  8'h80, 0, 0, 8'h80, 1, 1);
        vecs[3]  = mk(OP_ASR,  2,  8'h00, 1, 1, 8'hE0, 0, 2);
        vecs[4]  = mk(OP_LOAD, 0,  8'h5A, 0, 0, 8'h5A, 0, 1);
        vecs[5]  = mk(OP_ROR,  8,  8'h00, 1, 1, 8'h5A, 0, 8);
        vecs[6]  = mk(OP_ROL,  1,  8'h00, 1, 1, 8'hB4, 0, 1);
        vecs[7]  = mk(OP_SHR,  3,  8'h00, 1, 0, 8'hF6, 1, 3);
        vecs[8]  = mk(OP_NOP,  5,  8'h00, 0, 0, 8'hF6, 1, 1);
        vecs[9]  = mk(OP_RSVD, 5,  8'h00, 0, 0, 8'hF6, 1, 1);
        vecs[10] = mk(OP_SHL,  0,  8'h00, 0, 1, 8'hF6, 1, 1);
        vecs[11] = mk(OP_ASR,  3,  8'h00, 0, 0, 8'hFE, 1, 3);
        vecs[12] = mk(OP_ROL,  4,  8'h00, 0, 0, 8'hEF, 1, 4);
        vecs[13] = mk(OP_ROR,  15, 8'h00, 0, 0, 8'hDF, 1, 15);
        vecs[14] = mk(OP_LOAD, 0,  8'h3C, 0, 0, 8'h3C, 1, 1);
        vecs[15] = mk(OP_SHR,  2,  8'h00, 0, 0, 8'h0F, 0, 2);

        clear = 1'b1; start = 1'b0; op = OP_NOP; count = '0; data_in = '0;
        left_in = 1'b0; right_in = 1'b0;
        repeat (2) @(negedge clock);
        check("reset out", 32'(out), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset ser_out", 32'(ser_out), 32'h0);
        clear = 1'b0;

        foreach (vecs[i]) run_cmd($sformatf("vec%0d", i), vecs[i]);

        // Per-step view of SHL x3 from 0xA5 with right_in=1.
        run_cmd("seqB load", mk(OP_LOAD, 0, 8'hA5, 0, 0, 8'hA5, 0, 1));
        @(negedge clock);
        start = 1'b1; op = OP_SHL; count = 4'd3; right_in = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("seqB step1 out", 32'(out), 32'h4B);
        check("seqB step1 busy", 32'(busy), 32'd1);
        check("seqB step1 done", 32'(done), 32'd0);
        @(negedge clock);
        check("seqB step2 out", 32'(out), 32'h97);
        check("seqB step2 busy", 32'(busy), 32'd1);
        @(negedge clock);
        check("seqB step3 out", 32'(out), 32'h2F);
        check("seqB step3 busy", 32'(busy), 32'd0);
        check("seqB step3 done", 32'(done), 32'd1);
        check("seqB step3 ser", 32'(ser_out), 32'd1);

        // SHR x4 from 0xFF while a LOAD 0x00 is attempted during busy.
        run_cmd("seqC load", mk(OP_LOAD, 0, 8'hFF, 0, 0, 8'hFF, 1, 1));
        @(negedge clock);
        start = 1'b1; op = OP_SHR; count = 4'd4; left_in = 1'b0;
        @(negedge clock);
        op = OP_LOAD; data_in = 8'h00;
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 1) start = 1'b0;
            if (done) begin
                done_seen++;
                if (done_seen == 1) begin
                    check("seqC done cycle", 32'(k + 1), 32'd4);
                    check("seqC out", 32'(out), 32'h0F);
                end
            end
            @(negedge clock);
        end
        start = 1'b0;
        check("seqC single done", 32'(done_seen), 32'd1);
        check("seqC out after", 32'(out), 32'h0F);

        // SHR x10 aborted by clear after three step edges.
        @(negedge clock);
        start = 1'b1; op = OP_SHR; count = 4'd10; left_in = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("seqD pre-clear out", 32'(out), 32'h01);
        check("seqD pre-clear busy", 32'(busy), 32'd1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("seqD abort out", 32'(out), 32'h0);
        check("seqD abort busy", 32'(busy), 32'd0);
        check("seqD abort done", 32'(done), 32'd0);
        check("seqD abort ser", 32'(ser_out), 32'd0);
        done_seen = 0;
        busy_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) done_seen++;
            if (busy) busy_seen++;
            @(negedge clock);
        end
        check("seqD no done after abort", 32'(done_seen), 32'd0);
        check("seqD no busy after abort", 32'(busy_seen), 32'd0);
        run_cmd("seqD load", mk(OP_LOAD, 0, 8'h33, 0, 0, 8'h33, 0, 1));
        run_cmd("seqD shl0", mk(OP_SHL, 0, 8'h00, 0, 1, 8'h33, 0, 1));

        // clear and start on the same edge: start dropped.
        @(negedge clock);
        clear = 1'b1; start = 1'b1; op = OP_LOAD; data_in = 8'h77;
        @(negedge clock);
        clear = 1'b0; start = 1'b0;
        check("seqE clear out", 32'(out), 32'h0);
        @(negedge clock);
        check("seqE no done", 32'(done), 32'd0);
        check("seqE out still", 32'(out), 32'h0);
        run_cmd("seqE rsvd", mk(OP_RSVD, 3, 8'hFF, 0, 0, 8'h00, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
